shift_sequencer: RTL and testbench
==================================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have parameter STEP, default 8, meaning the maximum number of bit positions shifted or rotated per cycle (legal values 1, 2, 4, 8, 16, 32).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset, which is synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, the operand-generation request, sampled only in IDLE.
REQ-005 The block SHALL have port flush, input, 1, which abandons the in-flight operation.
REQ-006 The block SHALL have port I, input, 1, which selects an immediate operand.
REQ-007 The block SHALL have port mem_en, input, 1, which selects a memory-offset operand.
REQ-008 The block SHALL have port shifter, input, 12, the shifter-operand field of the instruction.
REQ-009 The block SHALL have port register, input, 32, the Rm value.
REQ-010 The block SHALL have port result, output, 32, the generated Val2.
REQ-011 The block SHALL have port busy, output, 1, high whenever state is not IDLE; it also serves as the pipeline stall request.
REQ-012 The block SHALL have port done, output, 1, a one-cycle pulse marking result valid.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-014 IDLE with start=1 (accept) SHALL capture the operand and the remaining count, then select the next state.
REQ-015 Operand precedence at accept SHALL be mem_en > I > register.
REQ-016 For mem_en, the loaded value SHALL be sign-extended shifter[11:0], with remaining=0.
REQ-017 For I (mem_en=0), the loaded value SHALL be {24'b0, shifter[7:0]}, op=ROR, remaining=2*shifter[11:8] (range 0..30).
REQ-018 Otherwise the loaded value SHALL be register, op=shifter[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR), remaining=shifter[11:7] (range 0..31).
REQ-019 A shift amount of 0 SHALL mean no shift (no ARM #0 special cases).
REQ-020 At accept, remaining=0 SHALL go to DONE; remaining>0 SHALL go to SHIFT.
REQ-021 Each SHIFT cycle SHALL apply op by k=min(remaining, STEP) and decrement remaining by k.
REQ-022 SHIFT SHALL go to DONE when the decremented count reaches 0.
REQ-023 ASR SHALL replicate bit 31; LSL and LSR SHALL fill zeros; ROR SHALL be modulo 32.
REQ-024 In DONE, done=1 for exactly one cycle, then the next state SHALL be IDLE unconditionally.
REQ-025 The done pulse SHALL occur accept+1+ceil(amount/STEP) cycles after accept.
REQ-026 result SHALL hold its final value from DONE until the next accept.
REQ-027 result SHALL not be guaranteed meaningful while busy=1.
REQ-028 start while busy=1 SHALL be ignored; the requester holds start until it observes busy=0.
REQ-029 start in the DONE cycle SHALL be ignored.
REQ-030 flush=1 in SHIFT or DONE SHALL force IDLE next cycle with no done pulse (a done already asserted in the flush cycle still counts).
REQ-031 flush SHALL have priority over start in IDLE: no accept.
REQ-032 shifter, register, I and mem_en SHALL be sampled only at accept; later changes SHALL not affect the operation.

Reset
REQ-033 rst=1 SHALL force state=IDLE, result=0, busy=0, done=0 and remaining=0 at the next edge, from any state including mid-SHIFT.
REQ-034 rst SHALL have priority over flush and start.

Structure
REQ-035 A shared package SHALL hold the shift-type codes (LSL/LSR/ASR/ROR), the FSM state encoding and the default STEP.
REQ-036 One combinational sub-module, shift_step, SHALL apply one op by 0..STEP positions.
REQ-037 The sequencer SHALL instantiate shift_step exactly once.

Verification
REQ-038 Test: I=1, mem_en=0, shifter=12'h4FF, start -> result=32'hFF000000; done at accept+2 (STEP=8).
REQ-039 Test: register=32'h80000000, shifter={5'd31,2'b10,5'b0}, start -> result=32'hFFFFFFFF; done at accept+5; busy high 5 cycles.
REQ-040 Test: mem_en=1, shifter=12'h800 -> result=32'hFFFFF800 at accept+1; I=1 also set -> same result.
REQ-041 Test: register=32'h00000001, ROR by 1 -> 32'h80000000; then LSL amount 0 -> register unchanged; done at accept+1.
REQ-042 Test: flush in 2nd SHIFT cycle of a 31-step op -> IDLE next cycle, no done; start held during busy -> accepted only once after busy=0.
REQ-043 Test: rst mid-SHIFT -> all outputs 0 next cycle; a following op completes correctly.

Source files
------------

// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer: shift-type codes, FSM state
// encoding and the default per-cycle shift step.
package shift_sequencer_pkg;

  // Shift-type codes, matching the shifter[6:5] field of the instruction.
  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_op_e;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // Default maximum number of bit positions moved per SHIFT cycle.
  localparam int DEFAULT_STEP = 8;

endpackage

// File: rtl/shift_sequencer_step.sv
// Combinational single-step shifter: applies one shift op to a 32-bit value
// by 0..32 positions. Module name is shift_step; the sequencer calls it once
// per SHIFT cycle with the step size it has chosen.
module shift_step
  import shift_sequencer_pkg::*;
(
  input  logic [31:0] i_value,
  input  shift_op_e   i_op,
  input  logic [5:0]  i_amount,
  output logic [31:0] o_value
);

  // Rotation only needs the amount modulo 32.
  logic [4:0]  w_rot_amt;
  logic [31:0] w_ror;

  assign w_rot_amt = i_amount[4:0];
  // A left shift by 32 yields zero, so a rotate by 0 degenerates cleanly to i_value.
  assign w_ror     = (i_value >> w_rot_amt) | (i_value << (6'd32 - {1'b0, w_rot_amt}));

  // Select the shifted value for the requested op.
  always_comb begin
    // NOTE: give every always_comb output a default first so no path can infer a latch.
    o_value = i_value;
    case (i_op)
      SH_LSL:  o_value = i_value << i_amount;
      SH_LSR:  o_value = i_value >> i_amount;
      SH_ASR:  o_value = $signed(i_value) >>> i_amount;
      SH_ROR:  o_value = w_ror;
      default: o_value = i_value;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle ARM-style Val2 operand generator. At accept it captures an
// operand (memory offset, rotated immediate, or shifted register), then
// shifts it by at most STEP positions per cycle until the count is used up,
// and pulses done for one cycle with the final value on result.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int STEP = DEFAULT_STEP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        flush,
  input  logic        I,
  input  logic        mem_en,
  input  logic [11:0] shifter,
  input  logic [31:0] register,
  output logic [31:0] result,
  output logic        busy,
  output logic        done
);

  localparam logic [5:0] STEP_W = 6'(STEP);

  state_e      r_state;
  shift_op_e   r_op;
  logic [31:0] r_result;
  logic [4:0]  r_remaining;
  logic        r_busy;
  logic        r_done;

  logic [31:0] w_load_val;
  shift_op_e   w_load_op;
  logic [4:0]  w_load_rem;
  logic [4:0]  w_k;
  logic [4:0]  w_rem_next;
  logic [31:0] w_step_val;

  // Operand decode at accept: mem_en beats I, I beats the register form.
  always_comb begin
    w_load_val = register;
    w_load_op  = shift_op_e'(shifter[6:5]);
    w_load_rem = shifter[11:7];
    if (mem_en) begin
      w_load_val = {{20{shifter[11]}}, shifter};
      w_load_op  = SH_LSL;
      w_load_rem = 5'd0;
    end else if (I) begin
      w_load_val = {24'b0, shifter[7:0]};
      w_load_op  = SH_ROR;
      w_load_rem = {shifter[11:8], 1'b0};
    end
  end

  // Step size for this cycle is min(remaining, STEP); remaining never exceeds 31.
  assign w_k        = ({1'b0, r_remaining} < STEP_W) ? r_remaining : STEP_W[4:0];
  assign w_rem_next = r_remaining - w_k;

  shift_step u_shift_step (
    .i_value  (r_result),
    .i_op     (r_op),
    .i_amount ({1'b0, w_k}),
    .o_value  (w_step_val)
  );

  // Sequencer FSM with registered result, busy and done.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      r_state     <= ST_IDLE;
      r_op        <= SH_LSL;
      r_result    <= 32'd0;
      r_remaining <= 5'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start && !flush) begin
            r_result    <= w_load_val;
            r_op        <= w_load_op;
            r_remaining <= w_load_rem;
            r_busy      <= 1'b1;
            if (w_load_rem == 5'd0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_SHIFT;
            end
          end
        end

        ST_SHIFT: begin
          if (flush) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end else begin
            r_result    <= w_step_val;
            r_remaining <= w_rem_next;
            if (w_rem_next == 5'd0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          // Leave unconditionally; flush here has the same effect.
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign result = r_result;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer with STEP=8.
module tb_shift_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        flush;
  logic        I;
  logic        mem_en;
  logic [11:0] shifter;
  logic [31:0] register;
  logic [31:0] result;
  logic        busy;
  logic        done;

  int checks;
  int failures;

  shift_sequencer #(.STEP(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .flush    (flush),
    .I        (I),
    .mem_en   (mem_en),
    .shifter  (shifter),
    .register (register),
    .result   (result),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait (bounded) for IDLE, present one request, and report the done latency
  // in cycles after the accept edge, busy cycles seen, and the result at done.
  task automatic run_op(input logic imm, input logic mem, input logic [11:0] sh,
                        input logic [31:0] rm, output int lat, output int bcyc,
                        output logic [31:0] res);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    I = imm; mem_en = mem; shifter = sh; register = rm; start = 1'b1;
    lat = 0; bcyc = 0; res = 'x;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) bcyc++;
      if (done) begin
        lat = c;
        res = result;
        break;
      end
    end
    if (lat == 0) begin
      checks++; failures++;
      $display("FAIL run_op_timeout sh=%h reg=%h got no done, required done within 64 cycles", sh, rm);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; I = 1'b0; mem_en = 1'b0;
    shifter = '0; register = '0;
    repeat (2) @(negedge clk);
    checks++; if (result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=%h", result, 32'd0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    rst = 1'b0;
  endtask

  task automatic test_immediate();
    int lat, bcyc;
    logic [31:0] res;
    run_op(1'b1, 1'b0, 12'h4FF, 32'h0, lat, bcyc, res);
    checks++; if (res !== 32'hFF000000) begin failures++; $display("FAIL imm_4ff_result got=%h exp=%h", res, 32'hFF000000); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL imm_4ff_latency got=%0d exp=2", lat); end
    // Change inputs with start low: result must hold, done must not repeat.
    shifter = 12'hABC; register = 32'h12345678; I = 1'b0;
    @(negedge clk);
    checks++; if (result !== 32'hFF000000) begin failures++; $display("FAIL imm_hold_result got=%h exp=%h", result, 32'hFF000000); end
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL imm_after_done got done=%b busy=%b exp 0 0", done, busy); end
    run_op(1'b1, 1'b0, 12'h0AB, 32'h0, lat, bcyc, res);
    checks++; if (res !== 32'h000000AB || lat !== 1) begin failures++; $display("FAIL imm_rot0 got=%h lat=%0d exp=%h lat=1", res, lat, 32'h000000AB); end
    run_op(1'b1, 1'b0, 12'h1F0, 32'h0, lat, bcyc, res);
    checks++; if (res !== 32'h0000003C || lat !== 2) begin failures++; $display("FAIL imm_rot2 got=%h lat=%0d exp=%h lat=2", res, lat, 32'h0000003C); end
  endtask

  task automatic test_register_shifts();
    int lat, bcyc;
    logic [31:0] res;
    run_op(1'b0, 1'b0, {5'd31, 2'b10, 5'b0}, 32'h80000000, lat, bcyc, res);
    checks++; if (res !== 32'hFFFFFFFF) begin failures++; $display("FAIL asr31_result got=%h exp=%h", res, 32'hFFFFFFFF); end
    checks++; if (lat !== 5) begin failures++; $display("FAIL asr31_latency got=%0d exp=5", lat); end
    checks++; if (bcyc !== 5) begin failures++; $display("FAIL asr31_busy_cycles got=%0d exp=5", bcyc); end
    run_op(1'b0, 1'b0, {5'd1, 2'b11, 5'b0}, 32'h00000001, lat, bcyc, res);
    checks++; if (res !== 32'h80000000 || lat !== 2) begin failures++; $display("FAIL ror1 got=%h lat=%0d exp=%h lat=2", res, lat, 32'h80000000); end
    run_op(1'b0, 1'b0, {5'd0, 2'b00, 5'b0}, 32'hDEADBEEF, lat, bcyc, res);
    checks++; if (res !== 32'hDEADBEEF || lat !== 1) begin failures++; $display("FAIL lsl0 got=%h lat=%0d exp=%h lat=1", res, lat, 32'hDEADBEEF); end
    run_op(1'b0, 1'b0, {5'd4, 2'b01, 5'b0}, 32'hF000000F, lat, bcyc, res);
    checks++; if (res !== 32'h0F000000 || lat !== 2) begin failures++; $display("FAIL lsr4 got=%h lat=%0d exp=%h lat=2", res, lat, 32'h0F000000); end
    run_op(1'b0, 1'b0, {5'd9, 2'b00, 5'b0}, 32'h00000003, lat, bcyc, res);
    checks++; if (res !== 32'h00000600 || lat !== 3) begin failures++; $display("FAIL lsl9 got=%h lat=%0d exp=%h lat=3", res, lat, 32'h00000600); end
    run_op(1'b0, 1'b0, {5'd16, 2'b11, 5'b0}, 32'h12345678, lat, bcyc, res);
    checks++; if (res !== 32'h56781234 || lat !== 3) begin failures++; $display("FAIL ror16 got=%h lat=%0d exp=%h lat=3", res, lat, 32'h56781234); end
    run_op(1'b0, 1'b0, {5'd8, 2'b10, 5'b0}, 32'h7F000000, lat, bcyc, res);
    checks++; if (res !== 32'h007F0000 || lat !== 2) begin failures++; $display("FAIL asr8_pos got=%h lat=%0d exp=%h lat=2", res, lat, 32'h007F0000); end
  endtask

  task automatic test_memory();
    int lat, bcyc;
    logic [31:0] res;
    run_op(1'b0, 1'b1, 12'h800, 32'h0, lat, bcyc, res);
    checks++; if (res !== 32'hFFFFF800 || lat !== 1) begin failures++; $display("FAIL mem_800 got=%h lat=%0d exp=%h lat=1", res, lat, 32'hFFFFF800); end
    run_op(1'b1, 1'b1, 12'h800, 32'h0, lat, bcyc, res);
    checks++; if (res !== 32'hFFFFF800 || lat !== 1) begin failures++; $display("FAIL mem_over_imm got=%h lat=%0d exp=%h lat=1", res, lat, 32'hFFFFF800); end
    run_op(1'b0, 1'b1, 12'h7FF, 32'hFFFFFFFF, lat, bcyc, res);
    checks++; if (res !== 32'h000007FF || lat !== 1) begin failures++; $display("FAIL mem_7ff got=%h lat=%0d exp=%h lat=1", res, lat, 32'h000007FF); end
  endtask

  task automatic test_flush();
    int dones;
    @(negedge clk);
    I = 1'b0; mem_en = 1'b0; shifter = {5'd31, 2'b10, 5'b0}; register = 32'h80000000;
    start = 1'b1;
    @(negedge clk);   // cycle 1: first SHIFT
    start = 1'b0;
    @(negedge clk);   // cycle 2: second SHIFT
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL flush_pre_busy got=%b exp=1", busy); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL flush_to_idle got busy=%b done=%b exp 0 0", busy, done); end
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++; if (dones !== 0) begin failures++; $display("FAIL flush_no_done got=%0d dones exp=0", dones); end
    // flush beats start in IDLE.
    start = 1'b1; flush = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_over_start got busy=%b exp=0", busy); end
    start = 1'b0; flush = 1'b0;
  endtask

  task automatic test_back_to_back();
    int guard, dones, accepts;
    logic [31:0] first_res;
    logic prev_busy;
    @(negedge clk);
    I = 1'b0; mem_en = 1'b0; shifter = {5'd31, 2'b10, 5'b0}; register = 32'h80000000;
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    // New request presented while busy; start stays high until busy drops.
    shifter = {5'd9, 2'b00, 5'b0}; register = 32'h00000003;
    first_res = 'x;
    guard = 0;
    while (busy && guard < 64) begin
      if (done) first_res = result;
      @(negedge clk);
      guard++;
    end
    checks++; if (first_res !== 32'hFFFFFFFF) begin failures++; $display("FAIL b2b_first_result got=%h exp=%h", first_res, 32'hFFFFFFFF); end
    // busy observed low with start still high: accepted at the next edge.
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got busy=%b exp=1", busy); end
    dones = 0; accepts = 0; prev_busy = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (done) begin
        dones++;
        checks++; if (result !== 32'h00000600) begin failures++; $display("FAIL b2b_second_result got=%h exp=%h", result, 32'h00000600); end
      end
      @(negedge clk);
      if (busy && !prev_busy) accepts++;
      prev_busy = busy;
    end
    checks++; if (dones !== 1 || accepts !== 0) begin failures++; $display("FAIL b2b_single_accept got dones=%0d extra_accepts=%0d exp 1 0", dones, accepts); end
  endtask

  task automatic test_reset_mid_shift();
    int lat, bcyc;
    logic [31:0] res;
    @(negedge clk);
    I = 1'b0; mem_en = 1'b0; shifter = {5'd31, 2'b10, 5'b0}; register = 32'h80000000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (result !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rst_mid got result=%h busy=%b done=%b exp 0 0 0", result, busy, done); end
    run_op(1'b0, 1'b0, {5'd16, 2'b11, 5'b0}, 32'h12345678, lat, bcyc, res);
    checks++; if (res !== 32'h56781234 || lat !== 3) begin failures++; $display("FAIL rst_then_op got=%h lat=%0d exp=%h lat=3", res, lat, 32'h56781234); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_immediate();
    test_register_shifts();
    test_memory();
    test_flush();
    test_back_to_back();
    test_reset_mid_shift();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
